// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// alu_seq_if : request/result handshake bundle between issue, alu_seq and WB
// Rev 1.0
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_A;
   logic [WIDTH-1:0] op_B;
   logic [3:0]       ALU_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [9:0]       comp_flag;
   logic             ovf;
   logic             op_err;

   modport slave (
      input  in_valid, op_A, op_B, ALU_op, out_ready,
      output in_ready, out_valid, result, comp_flag, ovf, op_err
   );

   modport master (
      output in_valid, op_A, op_B, ALU_op, out_ready,
      input  in_ready, out_valid, result, comp_flag, ovf, op_err
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : handshaked ALU with registered outputs and iterative shift-add MUL
// Rev 1.0
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 64
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH) + 1;

   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_CMP = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [9:0]       flags_q,  flags_d;
   logic             ovf_q,    ovf_d;
   logic             err_q,    err_d;
   logic             valid_q,  valid_d;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_b_neg;
   logic [WIDTH-1:0] w_sum_add;
   logic [WIDTH-1:0] w_sum_sub;
   logic [WIDTH-1:0] w_alu_res;
   logic [WIDTH-1:0] w_acc_step;
   logic [SHW-1:0]   w_amt;
   logic [9:0]       w_flags;
   logic             w_eq;
   logic             w_ltu;
   logic             w_lts;
   logic             w_ovf;
   logic             w_err;
   logic             w_in_ready;
   logic             w_accept;

   // While multiplying, flags must come from the captured operands, not the live bus.
   assign w_a       = (state_q == S_MUL) ? a_q : bus.op_A;
   assign w_b       = (state_q == S_MUL) ? b_q : bus.op_B;
   assign w_amt     = w_b[SHW-1:0];
   assign w_b_neg   = ~w_b + {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_sum_add = w_a + w_b;
   assign w_sum_sub = w_a + w_b_neg;

   assign w_eq  = (w_a == w_b);
   assign w_ltu = (w_a < w_b);
   assign w_lts = ($signed(w_a) < $signed(w_b));

   assign w_flags = {w_eq, ~w_eq,
                     w_ltu, ~w_ltu, (w_ltu | w_eq), (~w_ltu & ~w_eq),
                     w_lts, ~w_lts, (w_lts | w_eq), (~w_lts & ~w_eq)};

   always_comb begin
      w_alu_res = '0;
      w_ovf     = 1'b0;
      w_err     = 1'b0;
      case (bus.ALU_op)
         OP_ADD: begin
            w_alu_res = w_sum_add;
            w_ovf     = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                        (w_sum_add[WIDTH-1] != w_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_sum_sub;
            w_ovf     = (w_a[WIDTH-1] == w_b_neg[WIDTH-1]) &&
                        (w_sum_sub[WIDTH-1] != w_a[WIDTH-1]);
         end
         OP_AND:  w_alu_res = w_a & w_b;
         OP_OR:   w_alu_res = w_a | w_b;
         OP_NOT:  w_alu_res = ~w_b;
         OP_XOR:  w_alu_res = w_a ^ w_b;
         OP_CMP:  w_alu_res = w_sum_sub;
         OP_SHL:  w_alu_res = w_a << w_amt;
         OP_SHR:  w_alu_res = w_a >> w_amt;
         OP_SRA:  w_alu_res = $signed(w_a) >>> w_amt;
         OP_MUL:  w_alu_res = '0;
         default: w_err     = 1'b1;
      endcase
   end

   assign w_acc_step = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

   assign w_in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      valid_d  = valid_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            if ((state_q == S_HOLD) && bus.out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
            if (w_accept) begin
               a_d = bus.op_A;
               b_d = bus.op_B;
               if (bus.ALU_op == OP_MUL) begin
                  state_d  = S_MUL;
                  valid_d  = 1'b0;
                  cnt_d    = CNT_LOAD;
                  mcand_d  = bus.op_A;
                  mplier_d = bus.op_B;
                  acc_d    = '0;
               end else begin
                  state_d  = S_HOLD;
                  valid_d  = 1'b1;
                  result_d = w_alu_res;
                  flags_d  = w_flags;
                  ovf_d    = w_ovf;
                  err_d    = w_err;
               end
            end
         end
         S_MUL: begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = w_acc_step;
            cnt_d    = cnt_q - 1'b1;
            // The last step's partial sum is the product; register it directly.
            if (cnt_q == CNT_LAST) begin
               state_d  = S_HOLD;
               valid_d  = 1'b1;
               result_d = w_acc_step;
               flags_d  = w_flags;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = valid_q;
   assign bus.result    = result_q;
   assign bus.comp_flag = flags_q;
   assign bus.ovf       = ovf_q;
   assign bus.op_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : scoreboard bench for alu_seq (directed scenarios + op streams)
// Rev 1.0
// ============================================================================
module tb_alu_seq;
   localparam int WIDTH = 64;
   localparam int SHW   = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_CMP = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [9:0]       flg;
      logic             ovf;
      logic             err;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_checks;
   int   n_pass;

   logic [3:0]       s_op[16];
   logic [WIDTH-1:0] s_a[16];
   logic [WIDTH-1:0] s_b[16];

   alu_seq_if #(.WIDTH(WIDTH)) bus ();
   alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
      exp_t             e;
      logic [WIDTH-1:0] bn;
      logic             eq, ltu, lts;
      e   = '0;
      bn  = ~b + 64'd1;
      eq  = (a == b);
      ltu = (a < b);
      lts = ($signed(a) < $signed(b));
      e.flg = {eq, !eq, ltu, !ltu, ltu || eq, !ltu && !eq, lts, !lts, lts || eq, !lts && !eq};
      case (op)
         OP_ADD: begin e.res = a + b;  e.ovf = (a[63] == b[63])  && (e.res[63] != a[63]); end
         OP_SUB: begin e.res = a + bn; e.ovf = (a[63] == bn[63]) && (e.res[63] != a[63]); end
         OP_AND: e.res = a & b;
         OP_OR:  e.res = a | b;
         OP_NOT: e.res = ~b;
         OP_XOR: e.res = a ^ b;
         OP_CMP: e.res = a - b;
         OP_SHL: e.res = a << b[SHW-1:0];
         OP_SHR: e.res = a >> b[SHW-1:0];
         OP_SRA: e.res = $signed(a) >>> b[SHW-1:0];
         OP_MUL: e.res = a * b;
         default: begin e.res = '0; e.err = 1'b1; end
      endcase
      return e;
   endfunction

   function automatic exp_t observed();
      return {bus.result, bus.comp_flag, bus.ovf, bus.op_err};
   endfunction

   function automatic exp_t sb_pop();
      exp_t e;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      return e;
   endfunction

   // Presents a request during the clock-high phase and holds it until accepted.
   task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output bit ok);
      int n;
      n = 0;
      if (clk == 1'b0) begin
         @(posedge clk);
         #1;
      end
      bus.ALU_op   = op;
      bus.op_A     = a;
      bus.op_B     = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (ok) sb.push_back(model(op, a, b));
   endtask

   task automatic test_reset();
      exp_t zero;
      zero = '0;
      #2;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, observed()} !== {1'b1, 1'b0, zero})
         $display("FAIL reset_hold: rdy=%b vld=%b out=%h, required rdy=1 vld=0 out=0",
                  bus.in_ready, bus.out_valid, observed());
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.in_ready, bus.out_valid, observed()} !== {1'b1, 1'b0, zero})
         $display("FAIL reset_release: rdy=%b vld=%b out=%h, required rdy=1 vld=0 out=0",
                  bus.in_ready, bus.out_valid, observed());
      else n_pass++;
   endtask

   task automatic test_add_ovf();
      bit   ok;
      exp_t g, e;
      drive(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ok);
      @(negedge clk);
      g = observed();
      n_checks++;
      if (!ok || !bus.out_valid ||
          g !== {64'h8000_0000_0000_0000, 10'b01_0101_0101, 1'b1, 1'b0})
         $display("FAIL add_ovf: ok=%b vld=%b out=%h, required out=%h", ok, bus.out_valid, g,
                  {64'h8000_0000_0000_0000, 10'b01_0101_0101, 1'b1, 1'b0});
      else n_pass++;
      e = sb_pop();
      n_checks++;
      if (g !== e) $display("FAIL add_sb: got %h, required %h", g, e);
      else n_pass++;
   endtask

   task automatic test_cmp();
      bit   ok;
      exp_t g, e;
      drive(OP_CMP, 64'h8000_0000_0000_0000, 64'd1, ok);
      @(negedge clk);
      g = observed();
      n_checks++;
      if (!ok || !bus.out_valid ||
          g !== {64'h7FFF_FFFF_FFFF_FFFF, 10'b01_0101_1010, 1'b0, 1'b0})
         $display("FAIL cmp_flags: ok=%b vld=%b out=%h, required out=%h", ok, bus.out_valid, g,
                  {64'h7FFF_FFFF_FFFF_FFFF, 10'b01_0101_1010, 1'b0, 1'b0});
      else n_pass++;
      e = sb_pop();
      n_checks++;
      if (g !== e) $display("FAIL cmp_sb: got %h, required %h", g, e);
      else n_pass++;
   endtask

   task automatic test_mul();
      logic [WIDTH-1:0] ma[2];
      logic [WIDTH-1:0] mb[2];
      logic [WIDTH-1:0] mr[2];
      bit               ok;
      int               cyc, rdy_bad;
      exp_t             g, e;
      ma[0] = 64'd123456789; mb[0] = 64'd1000; mr[0] = 64'd123456789000;
      ma[1] = 64'd0;         mb[1] = 64'hDEAD; mr[1] = 64'd0;
      for (int k = 0; k < 2; k++) begin
         drive(OP_MUL, ma[k], mb[k], ok);
         cyc = 0;
         rdy_bad = 0;
         while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) break;
            if (bus.in_ready) rdy_bad++;
         end
         n_checks++;
         if (!ok || cyc != WIDTH + 1)
            $display("FAIL mul_latency[%0d]: ok=%b cycles=%0d, required %0d", k, ok, cyc, WIDTH + 1);
         else n_pass++;
         n_checks++;
         if (rdy_bad != 0)
            $display("FAIL mul_in_ready[%0d]: in_ready high %0d times, required 0", k, rdy_bad);
         else n_pass++;
         g = observed();
         n_checks++;
         if (g.res !== mr[k]) $display("FAIL mul_result[%0d]: got %h, required %h", k, g.res, mr[k]);
         else n_pass++;
         e = sb_pop();
         n_checks++;
         if (g !== e) $display("FAIL mul_sb[%0d]: got %h, required %h", k, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_mul();
      bit   ok;
      int   seen;
      exp_t zero;
      zero = '0;
      drive(OP_MUL, 64'd77, 64'd99, ok);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (!ok || bus.out_valid || !bus.in_ready || observed() !== zero)
         $display("FAIL mul_reset: ok=%b vld=%b rdy=%b out=%h, required vld=0 rdy=1 out=0",
                  ok, bus.out_valid, bus.in_ready, observed());
      else n_pass++;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      n_checks++;
      if (seen != 0 || !bus.in_ready)
         $display("FAIL mul_abort: out_valid seen %0d times rdy=%b, required 0 and rdy=1",
                  seen, bus.in_ready);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit   ok;
      exp_t g, e;
      bus.out_ready = 1'b0;
      drive(OP_XOR, 64'hFF00, 64'h0FF0, ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (!ok || !bus.out_valid || bus.in_ready || bus.result !== 64'hF0F0)
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h, required vld=1 rdy=0 res=f0f0",
                     i, bus.out_valid, bus.in_ready, bus.result);
         else n_pass++;
      end
      g = observed();
      e = sb_pop();
      n_checks++;
      if (g !== e) $display("FAIL bp_xor_sb: got %h, required %h", g, e);
      else n_pass++;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drive(OP_SRA, 64'hF000_0000_0000_0000, 64'd4, ok);
      g = observed();
      n_checks++;
      if (!ok || !bus.out_valid || g.res !== 64'hFF00_0000_0000_0000)
         $display("FAIL bp_sra: ok=%b vld=%b res=%h, required vld=1 res=ff00000000000000",
                  ok, bus.out_valid, g.res);
      else n_pass++;
      e = sb_pop();
      n_checks++;
      if (g !== e) $display("FAIL bp_sra_sb: got %h, required %h", g, e);
      else n_pass++;
   endtask

   task automatic test_illegal();
      bit   ok;
      exp_t g, e;
      drive(4'b1111, 64'd5, 64'd3, ok);
      @(negedge clk);
      g = observed();
      n_checks++;
      if (!ok || !bus.out_valid || g.res !== 64'd0 || g.err !== 1'b1)
         $display("FAIL illegal: vld=%b res=%h op_err=%b, required vld=1 res=0 op_err=1",
                  bus.out_valid, g.res, g.err);
      else n_pass++;
      e = sb_pop();
      n_checks++;
      if (g !== e) $display("FAIL illegal_sb: got %h, required %h", g, e);
      else n_pass++;
      drive(OP_AND, 64'hF0F0, 64'h3C3C, ok);
      @(negedge clk);
      g = observed();
      e = sb_pop();
      n_checks++;
      if (!ok || g.err !== 1'b0 || g !== e)
         $display("FAIL illegal_clear: got %h, required %h", g, e);
      else n_pass++;
   endtask

   // Streams s_op/s_a/s_b[0..n-1] with out_ready high and checks every result in order.
   task automatic run_stream(input int n, input bit check_tput, input string tag);
      fork
         begin
            bit ok;
            for (int i = 0; i < n; i++) begin
               drive(s_op[i], s_a[i], s_b[i], ok);
               n_checks++;
               if (!ok) $display("FAIL %s_accept[%0d]: request not accepted", tag, i);
               else n_pass++;
            end
         end
         begin
            int   got, first, last;
            exp_t g, e;
            got = 0; first = -1; last = -1;
            for (int c = 0; c < 3000 && got < n; c++) begin
               @(negedge clk);
               if (bus.out_valid) begin
                  g = observed();
                  e = sb_pop();
                  n_checks++;
                  if (g !== e)
                     $display("FAIL %s_result[%0d]: got %h, required %h", tag, got, g, e);
                  else n_pass++;
                  if (first < 0) first = c;
                  last = c;
                  got++;
               end
            end
            n_checks++;
            if (got != n) $display("FAIL %s_count: got %0d results, required %0d", tag, got, n);
            else n_pass++;
            if (check_tput) begin
               n_checks++;
               if (last - first != n - 1)
                  $display("FAIL %s_tput: %0d results spanned %0d cycles, required %0d",
                           tag, n, last - first + 1, n);
               else n_pass++;
            end
         end
      join
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         s_a[i] = {$urandom(), $urandom()};
         s_b[i] = {$urandom(), $urandom()};
      end
      s_op[0]  = OP_ADD;
      s_op[1]  = OP_SUB; s_a[1] = 64'h8000_0000_0000_0000; s_b[1] = 64'd1;
      s_op[2]  = OP_AND;
      s_op[3]  = OP_OR;
      s_op[4]  = OP_NOT;
      s_op[5]  = OP_XOR;
      s_op[6]  = OP_CMP; s_b[6] = s_a[6];
      s_op[7]  = OP_SHL; s_b[7] = 64'h1C0;
      s_op[8]  = OP_SHR; s_b[8] = 64'h0;
      s_op[9]  = OP_SRA; s_a[9] = 64'h8000_0000_0000_1234; s_b[9] = 64'd63;
      s_op[10] = OP_SHL; s_b[10] = 64'd63;
      s_op[11] = 4'b0000;
      run_stream(12, 1'b1, "b2b");
   endtask

   task automatic test_all_ops();
      for (int i = 0; i < 16; i++) begin
         s_op[i] = 4'(i);
         s_a[i]  = {$urandom(), $urandom()};
         s_b[i]  = {$urandom(), $urandom()};
      end
      run_stream(16, 1'b0, "allops");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.op_A      = '0;
      bus.op_B      = '0;
      bus.ALU_op    = 4'b0000;
      test_reset();
      test_add_ovf();
      test_cmp();
      test_mul();
      test_reset_mid_mul();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_all_ops();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
